// File: rtl/otbn_pq_bf_unit_if.sv
// Operand/result bundle between the OTBN controller and the PQ butterfly engine.
//   Controller -> engine : start_i, clear_i, mode_i, mod_q_i, qinv_i, twiddle_i,
//                          operand_a_i, operand_b_i
//   Engine -> controller : busy_o, done_o, result_a_o, result_b_o
//                          (err_o as well when OTBN_PQ_BF_RANGE_CHECK_EN is defined)
// The controller uses the master modport and the engine uses the slave modport.
interface otbn_pq_bf_unit_if #(
   parameter int unsigned WLEN  = 256,
   parameter int unsigned LaneW = 32
);
   logic              start_i;
   logic              clear_i;
   logic              mode_i;
   logic [LaneW-1:0]  mod_q_i;
   logic [LaneW-1:0]  qinv_i;
   logic [LaneW-1:0]  twiddle_i;
   logic [WLEN-1:0]   operand_a_i;
   logic [WLEN-1:0]   operand_b_i;
   logic              busy_o;
   logic              done_o;
   logic [WLEN-1:0]   result_a_o;
   logic [WLEN-1:0]   result_b_o;
`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
   logic              err_o;
`endif

   modport master (
      output start_i, clear_i, mode_i, mod_q_i, qinv_i, twiddle_i, operand_a_i, operand_b_i,
`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
      input  err_o,
`endif
      input  busy_o, done_o, result_a_o, result_b_o
   );

   modport slave (
      input  start_i, clear_i, mode_i, mod_q_i, qinv_i, twiddle_i, operand_a_i, operand_b_i,
`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
      output err_o,
`endif
      output busy_o, done_o, result_a_o, result_b_o
   );
endinterface

// File: rtl/otbn_pq_bf_unit.sv
// Multi-cycle vector NTT butterfly engine (CT / GS) for the OTBN PQ extension.
// WLEN-wide operands are split into WLEN/LaneW lanes; LanesPerCycle lanes are
// processed per Busy cycle using Montgomery multiplication by a shared twiddle.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : start/clear/mode, modulus q, qinv = -q^-1 mod 2^LaneW, twiddle,
//                   operand vectors a/b in; busy, one-cycle done, result vectors out.
// Optional feature: define OTBN_PQ_BF_RANGE_CHECK_EN to add bus.err_o, which flags
// out-of-range operand lanes or twiddle at start acceptance.
module otbn_pq_bf_unit #(
   parameter int unsigned WLEN          = 256,
   parameter int unsigned LaneW         = 32,
   parameter int unsigned LanesPerCycle = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   otbn_pq_bf_unit_if.slave bus
);

   localparam int unsigned NumLanes  = WLEN / LaneW;
   localparam int unsigned NumGroups = NumLanes / LanesPerCycle;
   localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
   localparam int unsigned LaneIdxW  = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam int unsigned ExtW      = LaneW + 1;
   localparam int unsigned ProdW     = 2 * LaneW;
   localparam int unsigned SumW      = 2 * LaneW + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

   typedef logic [LaneW-1:0] lane_t;
   typedef logic [NumLanes-1:0][LaneW-1:0] vec_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   // (x + y) mod q for x, y < q
   function automatic lane_t add_q(lane_t x, lane_t y, lane_t q);
      logic [ExtW-1:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, q}) begin
         s = s - {1'b0, q};
      end
      return s[LaneW-1:0];
   endfunction

   // (x - y) mod q for x, y < q; the extra top bit is the borrow
   function automatic lane_t sub_q(lane_t x, lane_t y, lane_t q);
      logic [ExtW-1:0] d;
      d = {1'b0, x} - {1'b0, y};
      return d[LaneW] ? (d[LaneW-1:0] + q) : d[LaneW-1:0];
   endfunction

   // Montgomery product x*y*2^-LaneW mod q with a single final subtraction
   function automatic lane_t mont_mul(lane_t x, lane_t y, lane_t q, lane_t qinv);
      logic [ProdW-1:0] t;
      lane_t            m;
      logic [SumW-1:0]  s;
      logic [ExtW-1:0]  u;
      t = ProdW'(x) * ProdW'(y);
      m = t[LaneW-1:0] * qinv;
      s = SumW'(t) + SumW'(ProdW'(m) * ProdW'(q));
      u = ExtW'(s >> LaneW);
      return (u >= {1'b0, q}) ? LaneW'(u - {1'b0, q}) : u[LaneW-1:0];
   endfunction

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            start_acc;
   logic            group_en;

   logic [CntW-1:0] cnt_q;
   logic            mode_q;
   lane_t           modq_q;
   lane_t           qinv_q;
   lane_t           w_q;
   vec_t            a_q, b_q;
   vec_t            res_a_q, res_b_q;

   logic [LaneIdxW-1:0] lane_idx   [LanesPerCycle];
   lane_t               lane_a     [LanesPerCycle];
   lane_t               lane_b     [LanesPerCycle];
   lane_t               lane_diff  [LanesPerCycle];
   lane_t               lane_mop   [LanesPerCycle];
   lane_t               lane_prod  [LanesPerCycle];
   lane_t               lane_a_new [LanesPerCycle];
   lane_t               lane_b_new [LanesPerCycle];

   // Next-state and registered-output decode; clear_i overrides everything
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      group_en  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.start_i) begin
               state_d   = StBusy;
               start_acc = 1'b1;
            end
         end
         StBusy: begin
            group_en = 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (bus.clear_i) begin
         state_d   = StIdle;
         start_acc = 1'b0;
         group_en  = 1'b0;
      end

      busy_d = (state_d == StBusy);
      done_d = (state_d == StDone);
   end

   // State and status flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Per-lane butterfly for the current lane group. One Montgomery multiplier per
   // lane is shared: CT multiplies b by w before add/sub, GS multiplies (a-b) by w after.
   always_comb begin
      for (int unsigned l = 0; l < LanesPerCycle; l++) begin
         lane_idx[l]   = LaneIdxW'(32'(cnt_q) * LanesPerCycle + l);
         lane_a[l]     = a_q[lane_idx[l]];
         lane_b[l]     = b_q[lane_idx[l]];
         lane_diff[l]  = sub_q(lane_a[l], lane_b[l], modq_q);
         lane_mop[l]   = mode_q ? lane_diff[l] : lane_b[l];
         lane_prod[l]  = mont_mul(lane_mop[l], w_q, modq_q, qinv_q);
         lane_a_new[l] = add_q(lane_a[l], mode_q ? lane_b[l] : lane_prod[l], modq_q);
         lane_b_new[l] = mode_q ? lane_prod[l] : sub_q(lane_a[l], lane_prod[l], modq_q);
      end
   end

   // Operand capture on accept, group write-back while Busy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         modq_q  <= '0;
         qinv_q  <= '0;
         w_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_a_q <= '0;
         res_b_q <= '0;
      end else if (bus.clear_i) begin
         cnt_q <= '0;
      end else if (start_acc) begin
         cnt_q  <= '0;
         mode_q <= bus.mode_i;
         modq_q <= bus.mod_q_i;
         qinv_q <= bus.qinv_i;
         w_q    <= bus.twiddle_i;
         a_q    <= bus.operand_a_i;
         b_q    <= bus.operand_b_i;
      end else if (group_en) begin
         cnt_q <= cnt_q + CntW'(1);
         for (int unsigned l = 0; l < LanesPerCycle; l++) begin
            res_a_q[lane_idx[l]] <= lane_a_new[l];
            res_b_q[lane_idx[l]] <= lane_b_new[l];
         end
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.result_a_o = res_a_q;
   assign bus.result_b_o = res_b_q;

`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
   vec_t in_a, in_b;
   logic range_err;
   logic err_q;

   assign in_a = bus.operand_a_i;
   assign in_b = bus.operand_b_i;

   // Any operand lane or the twiddle not reduced mod q
   always_comb begin
      range_err = (bus.twiddle_i >= bus.mod_q_i);
      for (int unsigned i = 0; i < NumLanes; i++) begin
         if ((in_a[i] >= bus.mod_q_i) || (in_b[i] >= bus.mod_q_i)) begin
            range_err = 1'b1;
         end
      end
   end

   // Error flag sampled at accept, held until the next accept or clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (bus.clear_i) begin
         err_q <= 1'b0;
      end else if (start_acc) begin
         err_q <= range_err;
      end
   end

   assign bus.err_o = err_q;
`endif

endmodule

// File: tb/tb_otbn_pq_bf_unit.sv
// Self-checking bench for otbn_pq_bf_unit (LaneW=16, LanesPerCycle=2, 16 lanes).
// Fixed vectors from a table plus random operands checked against a modular
// arithmetic reference model, and hand-written control sequences.
module tb_otbn_pq_bf_unit;

   localparam int unsigned WLEN = 256;
   localparam int unsigned LW   = 16;
   localparam int unsigned LPC  = 2;
   localparam int unsigned NL   = WLEN / LW;
   localparam int          LAT  = 9;

   typedef logic [NL-1:0][LW-1:0] vec_t;

   typedef struct {
      logic          mode;
      logic [LW-1:0] w;
      logic [LW-1:0] a;
      logic [LW-1:0] b;
      logic [LW-1:0] exp_a;
      logic [LW-1:0] exp_b;
   } tv_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   otbn_pq_bf_unit_if #(.WLEN(WLEN), .LaneW(LW)) bus_if ();

   otbn_pq_bf_unit #(
      .WLEN          (WLEN),
      .LaneW         (LW),
      .LanesPerCycle (LPC)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   task automatic check(input string name, input logic [WLEN-1:0] act, input logic [WLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t rep(input logic [LW-1:0] x);
      vec_t v;
      for (int i = 0; i < NL; i++) v[i] = x;
      return v;
   endfunction

   // 2^-16 mod q by search
   function automatic longint r_inv(input longint q);
      for (longint k = 1; k < q; k++) if (((k << LW) % q) == 1) return k;
      return 0;
   endfunction

   // -q^-1 mod 2^16 by Newton iteration
   function automatic logic [LW-1:0] calc_qinv(input longint q);
      longint inv;
      inv = q;
      for (int i = 0; i < 5; i++) inv = (inv * (2 - q * inv)) & 64'hFFFF;
      return LW'((65536 - inv) & 64'hFFFF);
   endfunction

   task automatic drive(input logic mode, input logic [LW-1:0] q, input logic [LW-1:0] qinv,
                        input logic [LW-1:0] w, input vec_t a, input vec_t b);
      bus_if.mode_i      = mode;
      bus_if.mod_q_i     = q;
      bus_if.qinv_i      = qinv;
      bus_if.twiddle_i   = w;
      bus_if.operand_a_i = a;
      bus_if.operand_b_i = b;
   endtask

   // Issue one start, scramble inputs after acceptance, wait (bounded) for done
   task automatic run_op(input logic mode, input logic [LW-1:0] q, input logic [LW-1:0] qinv,
                         input logic [LW-1:0] w, input vec_t a, input vec_t b,
                         output int lat, output logic busy1);
      drive(mode, q, qinv, w, a, b);
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      lat   = 1;
      busy1 = bus_if.busy_o;
      drive(~mode, LW'($urandom), LW'($urandom), LW'($urandom), {8{$urandom}}, {8{$urandom}});
      while (!bus_if.done_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      tv_t  vecs [9];
      int   lat;
      int   dones;
      logic busy1;
      vec_t a_arr, b_arr, ea, eb;

      vecs[0] = '{1'b0, 16'd2285, 16'd3000, 16'd1000, 16'd671,  16'd2000};
      vecs[1] = '{1'b0, 16'd2285, 16'd100,  16'd200,  16'd300,  16'd3229};
      vecs[2] = '{1'b1, 16'd2285, 16'd100,  16'd200,  16'd300,  16'd3229};
      vecs[3] = '{1'b1, 16'd1,    16'd5,    16'd3,    16'd8,    16'd338};
      vecs[4] = '{1'b0, 16'd1,    16'd5,    16'd3,    16'd512,  16'd2827};
      vecs[5] = '{1'b0, 16'd2285, 16'd3328, 16'd3328, 16'd3327, 16'd0};
      vecs[6] = '{1'b1, 16'd2285, 16'd3328, 16'd3328, 16'd3327, 16'd0};
      vecs[7] = '{1'b0, 16'd2285, 16'd0,    16'd0,    16'd0,    16'd0};
      vecs[8] = '{1'b1, 16'd2285, 16'd0,    16'd3328, 16'd3328, 16'd1};

      rst_n          = 1'b0;
      bus_if.start_i = 1'b0;
      bus_if.clear_i = 1'b0;
      drive(1'b0, '0, '0, '0, '0, '0);
      repeat (3) @(negedge clk);
      check("reset_busy", WLEN'(bus_if.busy_o), '0);
      check("reset_done", WLEN'(bus_if.done_o), '0);
      check("reset_res_a", bus_if.result_a_o, '0);
      check("reset_res_b", bus_if.result_b_o, '0);
`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
      check("reset_err", WLEN'(bus_if.err_o), '0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed vectors, q = 3329
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].mode, 16'd3329, 16'd3327, vecs[i].w, rep(vecs[i].a), rep(vecs[i].b), lat, busy1);
         check($sformatf("vec%0d_busy", i), WLEN'(busy1), WLEN'(1));
         check($sformatf("vec%0d_latency", i), WLEN'(lat), WLEN'(LAT));
         check($sformatf("vec%0d_res_a", i), bus_if.result_a_o, rep(vecs[i].exp_a));
         check($sformatf("vec%0d_res_b", i), bus_if.result_b_o, rep(vecs[i].exp_b));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), WLEN'({bus_if.done_o, bus_if.busy_o}), '0);
      end

      // Random moduli and per-lane operands against the reference model
      for (int n = 0; n < 20; n++) begin
         longint q, ri, w, av, bv, p, d;
         logic   m;
         q  = longint'($urandom_range(3, 32767)) | 1;
         ri = r_inv(q);
         m  = 1'($urandom_range(0, 1));
         w  = longint'($urandom_range(0, 32'(q - 1)));
         for (int i = 0; i < NL; i++) begin
            av = longint'($urandom_range(0, 32'(q - 1)));
            bv = longint'($urandom_range(0, 32'(q - 1)));
            a_arr[i] = LW'(av);
            b_arr[i] = LW'(bv);
            if (!m) begin
               p     = ((bv * w) % q) * ri % q;
               ea[i] = LW'((av + p) % q);
               eb[i] = LW'((av - p + q) % q);
            end else begin
               d     = (av - bv + q) % q;
               ea[i] = LW'((av + bv) % q);
               eb[i] = LW'(((d * w) % q) * ri % q);
            end
         end
         run_op(m, LW'(q), calc_qinv(q), LW'(w), a_arr, b_arr, lat, busy1);
         check($sformatf("rand%0d_latency", n), WLEN'(lat), WLEN'(LAT));
         check($sformatf("rand%0d_res_a", n), bus_if.result_a_o, ea);
         check($sformatf("rand%0d_res_b", n), bus_if.result_b_o, eb);
         @(negedge clk);
      end

      // start_i during Busy must be ignored
      drive(1'b0, 16'd3329, 16'd3327, 16'd2285, rep(16'd3000), rep(16'd1000));
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      lat = 1;
      while (!bus_if.done_o && lat < 40) begin
         bus_if.start_i = (lat == 3);
         if (lat == 3) drive(1'b1, 16'd3329, 16'd3327, 16'd2285, rep(16'd100), rep(16'd200));
         @(negedge clk);
         lat++;
      end
      bus_if.start_i = 1'b0;
      check("busy_start_latency", WLEN'(lat), WLEN'(LAT));
      check("busy_start_res_a", bus_if.result_a_o, rep(16'd671));
      check("busy_start_res_b", bus_if.result_b_o, rep(16'd2000));
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_if.done_o) dones++;
      end
      check("busy_start_no_restart", WLEN'(dones), '0);

      // clear_i mid-Busy: idle next cycle, no done
      drive(1'b0, 16'd3329, 16'd3327, 16'd2285, rep(16'd100), rep(16'd200));
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      lat = 1;
      while (lat < 4) begin
         @(negedge clk);
         lat++;
      end
      check("clear_busy_before", WLEN'(bus_if.busy_o), WLEN'(1));
      bus_if.clear_i = 1'b1;
      @(negedge clk);
      bus_if.clear_i = 1'b0;
      check("clear_busy_after", WLEN'(bus_if.busy_o), '0);
      dones = 0;
      repeat (12) begin
         if (bus_if.done_o || bus_if.busy_o) dones++;
         @(negedge clk);
      end
      check("clear_no_done", WLEN'(dones), '0);

      // clear_i beats start_i in the same cycle
      bus_if.start_i = 1'b1;
      bus_if.clear_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      bus_if.clear_i = 1'b0;
      check("clear_beats_start", WLEN'(bus_if.busy_o), '0);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_if.done_o) dones++;
      end
      check("clear_beats_start_no_done", WLEN'(dones), '0);

      // Engine still usable after clear
      run_op(1'b1, 16'd3329, 16'd3327, 16'd2285, rep(16'd100), rep(16'd200), lat, busy1);
      check("post_clear_latency", WLEN'(lat), WLEN'(LAT));
      check("post_clear_res_b", bus_if.result_b_o, rep(16'd3229));
      @(negedge clk);

      // Reset asserted mid-Busy
      drive(1'b0, 16'd3329, 16'd3327, 16'd2285, rep(16'd3000), rep(16'd1000));
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", WLEN'(bus_if.busy_o), '0);
      check("midrst_done", WLEN'(bus_if.done_o), '0);
      check("midrst_res_a", bus_if.result_a_o, '0);
      check("midrst_res_b", bus_if.result_b_o, '0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(1'b0, 16'd3329, 16'd3327, 16'd2285, rep(16'd3000), rep(16'd1000), lat, busy1);
      check("post_rst_latency", WLEN'(lat), WLEN'(LAT));
      check("post_rst_res_a", bus_if.result_a_o, rep(16'd671));
      check("post_rst_res_b", bus_if.result_b_o, rep(16'd2000));
      @(negedge clk);

`ifdef OTBN_PQ_BF_RANGE_CHECK_EN
      // One lane equal to q flags err_o, done still pulses
      a_arr    = rep(16'd1);
      a_arr[5] = 16'd3329;
      run_op(1'b0, 16'd3329, 16'd3327, 16'd2285, a_arr, rep(16'd2), lat, busy1);
      check("range_err_set", WLEN'(bus_if.err_o), WLEN'(1));
      check("range_err_latency", WLEN'(lat), WLEN'(LAT));
      @(negedge clk);
      check("range_err_held", WLEN'(bus_if.err_o), WLEN'(1));
      bus_if.clear_i = 1'b1;
      @(negedge clk);
      bus_if.clear_i = 1'b0;
      check("range_err_clear", WLEN'(bus_if.err_o), '0);
      run_op(1'b0, 16'd3329, 16'd3327, 16'd3329, rep(16'd1), rep(16'd2), lat, busy1);
      check("range_err_twiddle", WLEN'(bus_if.err_o), WLEN'(1));
      @(negedge clk);
      run_op(1'b1, 16'd3329, 16'd3327, 16'd2285, rep(16'd1), rep(16'd2), lat, busy1);
      check("range_err_clean", WLEN'(bus_if.err_o), '0);
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
